timer_bank: RTL and testbench

Multi-channel timer bank: the parametrised successor of the single up/down counter. CHANNELS independent counters share one programmable prescaler. Each channel selects its direction at run time and runs one-shot or periodic, with a sticky interrupt flag and a stop command. It sits beside the clock dividers and feeds the interrupt aggregator; the optional PWM output drives LED and motor outputs.

---
 rtl/timer_bank.sv | 161 ++++++++++++++++
 tb/tb_timer_bank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - multi-channel up/down timer bank with shared prescaler (optional PWM via TIMER_BANK_PWM_EN)
module timer_bank #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int PSC_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [PSC_WIDTH-1:0]        psc,
    input  logic [CHANNELS*WIDTH-1:0]   top,
    input  logic [CHANNELS-1:0]         dir,
    input  logic [CHANNELS-1:0]         periodic,
    input  logic [CHANNELS-1:0]         start,
    input  logic [CHANNELS-1:0]         stop,
    input  logic [CHANNELS-1:0]         clr_it,
`ifdef TIMER_BANK_PWM_EN
    input  logic [CHANNELS*WIDTH-1:0]   cmp,
`endif
    output logic [CHANNELS*WIDTH-1:0]   cnt,
    output logic [CHANNELS-1:0]         busy,
    output logic [CHANNELS-1:0]         it,
    output logic                        irq
`ifdef TIMER_BANK_PWM_EN
    ,
    output logic [CHANNELS-1:0]         pwm
`endif
);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [PSC_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
    logic                 tick;

    state_e           state_q [CHANNELS];
    state_e           state_d [CHANNELS];
    logic [WIDTH-1:0] cnt_q   [CHANNELS];
    logic [WIDTH-1:0] cnt_d   [CHANNELS];
    logic [WIDTH-1:0] top_s_q [CHANNELS];
    logic [WIDTH-1:0] top_s_d [CHANNELS];
    logic [WIDTH-1:0] top_w   [CHANNELS];
    logic [WIDTH-1:0] load_w  [CHANNELS];
    logic [CHANNELS-1:0] dir_s_q, dir_s_d;
    logic [CHANNELS-1:0] it_q, it_d;
    logic                irq_q;

    // Prescaler: tick on psc_cnt==psc; an out-of-range count after a psc change restarts silently
    assign tick = (psc_cnt_q == psc);

    always_comb begin
        psc_cnt_d = psc_cnt_q + {{(PSC_WIDTH-1){1'b0}}, 1'b1};
        if (tick || (psc_cnt_q > psc)) begin
            psc_cnt_d = '0;
        end
    end

    // Per-channel bus slicing and the load value implied by the live top/dir inputs
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign top_w[g]               = top[g*WIDTH +: WIDTH];
        assign load_w[g]              = dir[g] ? '0 : top_w[g];
        assign cnt[g*WIDTH +: WIDTH]  = cnt_q[g];
        assign busy[g]                = (state_q[g] == S_RUN);
    end

    assign it  = it_q;
    assign irq = irq_q;

    // Channel FSMs: start arms, terminal events reload from the re-latched shadow, stop aborts
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            top_s_d[i] = top_s_q[i];
            dir_s_d[i] = dir_s_q[i];
            it_d[i]    = it_q[i];
            if (clr_it[i]) begin
                it_d[i] = 1'b0;
            end
            case (state_q[i])
                S_IDLE: begin
                    if (start[i]) begin
                        top_s_d[i] = top_w[i];
                        dir_s_d[i] = dir[i];
                        cnt_d[i]   = load_w[i];
                        state_d[i] = S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop[i]) begin
                        cnt_d[i]   = load_w[i];
                        state_d[i] = S_IDLE;
                    end else if (tick) begin
                        if (cnt_q[i] == (dir_s_q[i] ? top_s_q[i] : '0)) begin
                            it_d[i]    = 1'b1;
                            top_s_d[i] = top_w[i];
                            dir_s_d[i] = dir[i];
                            cnt_d[i]   = load_w[i];
                            if (!periodic[i]) begin
                                state_d[i] = S_IDLE;
                            end
                        end else if (dir_s_q[i]) begin
                            cnt_d[i] = cnt_q[i] + ONE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - ONE;
                        end
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

`ifdef TIMER_BANK_PWM_EN
    logic [CHANNELS-1:0] pwm_q, pwm_d;

    // PWM follows next-state count so it lines up with cnt and drops on the same edge as busy
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = (state_d[i] == S_RUN) && (cnt_d[i] < cmp[i*WIDTH +: WIDTH]);
        end
    end

    // PWM output register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;
`endif

    // State registers for prescaler, channels and the registered interrupt
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            psc_cnt_q <= '0;
            dir_s_q   <= '0;
            it_q      <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
                top_s_q[i] <= '0;
            end
        end else begin
            psc_cnt_q <= psc_cnt_d;
            dir_s_q   <= dir_s_d;
            it_q      <= it_d;
            irq_q     <= |it_q;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                top_s_q[i] <= top_s_d[i];
            end
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - self-checking bench for timer_bank (table vectors plus multi-cycle sequences)
module tb_timer_bank;

    localparam int W  = 8;
    localparam int CH = 2;
    localparam int PW = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic [PW-1:0]   psc;
    logic [W-1:0]    top0, top1, cmp0, cmp1;
    logic [CH-1:0]   dir, periodic, start, stop, clr_it;
    logic [CH*W-1:0] cnt;
    logic [CH-1:0]   busy, it;
    logic            irq;
`ifdef TIMER_BANK_PWM_EN
    logic [CH-1:0]   pwm;
`endif

    timer_bank #(.WIDTH(W), .CHANNELS(CH), .PSC_WIDTH(PW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .psc      (psc),
        .top      ({top1, top0}),
        .dir      (dir),
        .periodic (periodic),
        .start    (start),
        .stop     (stop),
        .clr_it   (clr_it),
`ifdef TIMER_BANK_PWM_EN
        .cmp      ({cmp1, cmp0}),
`endif
        .cnt      (cnt),
        .busy     (busy),
        .it       (it),
        .irq      (irq)
`ifdef TIMER_BANK_PWM_EN
        ,
        .pwm      (pwm)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] top;
        logic         dir;
        logic         per;
        logic         st;
        logic         sp;
        logic         cl;
        logic [W-1:0] ecnt;
        logic         eb;
        logic         eit;
        logic         eirq;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input int t, input bit d, input bit p, input bit s, input bit sp,
                                input bit c, input int ec, input bit eb, input bit ei, input bit eq);
        vec_t v;
        v.top = W'(t); v.dir = d; v.per = p; v.st = s; v.sp = sp; v.cl = c;
        v.ecnt = W'(ec); v.eb = eb; v.eit = ei; v.eirq = eq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t_ev[3];
        int nev;
        int nchg;
        int npwm;
        logic [W-1:0] prev;

        rstn = 1'b0; psc = '0; top0 = '0; top1 = '0; cmp0 = '0; cmp1 = '0;
        dir = '0; periodic = '0; start = '0; stop = '0; clr_it = '0;

        //            top dir per st sp cl  cnt b it irq
        tbl.push_back(mk(4, 1, 1, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(4, 1, 1, 1, 0, 0,  0, 1, 0, 0));
        tbl.push_back(mk(4, 1, 1, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(4, 1, 1, 0, 0, 0,  2, 1, 0, 0));
        tbl.push_back(mk(4, 1, 1, 0, 0, 0,  3, 1, 0, 0));
        tbl.push_back(mk(4, 1, 1, 0, 0, 0,  4, 1, 0, 0));
        tbl.push_back(mk(4, 1, 1, 0, 0, 0,  0, 1, 1, 0));
        tbl.push_back(mk(4, 1, 1, 0, 0, 0,  1, 1, 1, 1));
        tbl.push_back(mk(4, 1, 1, 0, 0, 1,  2, 1, 0, 1));
        tbl.push_back(mk(4, 1, 1, 0, 0, 0,  3, 1, 0, 0));
        tbl.push_back(mk(4, 1, 1, 0, 0, 0,  4, 1, 0, 0));
        tbl.push_back(mk(4, 1, 1, 0, 0, 1,  0, 1, 1, 0));
        tbl.push_back(mk(4, 1, 1, 0, 1, 0,  0, 0, 1, 1));
        tbl.push_back(mk(4, 1, 1, 0, 0, 1,  0, 0, 0, 1));
        tbl.push_back(mk(4, 1, 1, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(3, 0, 0, 1, 0, 0,  3, 1, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 0, 0,  2, 1, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 0, 0,  0, 1, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 0, 0,  3, 0, 1, 0));
        tbl.push_back(mk(3, 0, 0, 0, 0, 0,  3, 0, 1, 1));
        tbl.push_back(mk(3, 0, 0, 0, 0, 1,  3, 0, 0, 1));
        tbl.push_back(mk(3, 0, 0, 0, 0, 0,  3, 0, 0, 0));
        tbl.push_back(mk(4, 1, 1, 1, 0, 0,  0, 1, 0, 0));
        tbl.push_back(mk(4, 1, 1, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(4, 1, 1, 0, 0, 0,  2, 1, 0, 0));
        tbl.push_back(mk(4, 1, 1, 0, 1, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,  0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0,  0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 1,  0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(4, 1, 1, 1, 0, 0,  0, 1, 0, 0));
        tbl.push_back(mk(6, 1, 1, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(6, 1, 1, 0, 0, 0,  2, 1, 0, 0));
        tbl.push_back(mk(6, 1, 1, 0, 0, 0,  3, 1, 0, 0));
        tbl.push_back(mk(6, 1, 1, 0, 0, 0,  4, 1, 0, 0));
        tbl.push_back(mk(6, 1, 1, 0, 0, 0,  0, 1, 1, 0));
        tbl.push_back(mk(6, 1, 1, 0, 0, 1,  1, 1, 0, 1));
        tbl.push_back(mk(6, 1, 1, 0, 0, 0,  2, 1, 0, 0));
        tbl.push_back(mk(6, 1, 1, 0, 0, 0,  3, 1, 0, 0));
        tbl.push_back(mk(6, 1, 1, 0, 0, 0,  4, 1, 0, 0));
        tbl.push_back(mk(6, 1, 1, 0, 0, 0,  5, 1, 0, 0));
        tbl.push_back(mk(6, 1, 1, 0, 0, 0,  6, 1, 0, 0));
        tbl.push_back(mk(6, 1, 1, 0, 0, 0,  0, 1, 1, 0));
        tbl.push_back(mk(6, 1, 1, 0, 1, 0,  0, 0, 1, 1));
        tbl.push_back(mk(6, 1, 1, 0, 0, 1,  0, 0, 0, 1));
        tbl.push_back(mk(5, 0, 1, 1, 0, 0,  5, 1, 0, 0));
        tbl.push_back(mk(5, 0, 1, 1, 0, 0,  4, 1, 0, 0));
        tbl.push_back(mk(5, 0, 1, 0, 1, 0,  5, 0, 0, 0));

        step();
        step();
        chk("reset_state", {cnt, busy, it, irq}, '0);
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            top0 = tbl[i].top; dir[0] = tbl[i].dir; periodic[0] = tbl[i].per;
            start[0] = tbl[i].st; stop[0] = tbl[i].sp; clr_it[0] = tbl[i].cl;
            step();
            start = '0; stop = '0; clr_it = '0;
            chk($sformatf("vec%0d cnt/busy/it/irq", i), {cnt[W-1:0], busy[0], it[0], irq},
                {tbl[i].ecnt, tbl[i].eb, tbl[i].eit, tbl[i].eirq});
        end
        chk("ch1_untouched", {cnt[2*W-1:W], busy[1], it[1]}, '0);

        // Prescaler: psc=2, top=1, periodic up -> terminal events every 6 cycles after the first
        psc = 8'd2; top0 = 8'd1; dir[0] = 1'b1; periodic[0] = 1'b1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        nev = 0; nchg = 0; prev = cnt[W-1:0];
        for (int c = 0; c < 60 && nev < 3; c++) begin
            step();
            if (nev > 0 && cnt[W-1:0] != prev) nchg++;
            prev = cnt[W-1:0];
            clr_it[0] = 1'b0;
            if (it[0]) begin
                t_ev[nev] = c;
                nev++;
                clr_it[0] = 1'b1;
            end
        end
        clr_it[0] = 1'b0;
        chk("psc_event_count", nev, 3);
        if (nev == 3) begin
            chk("psc_period_1", t_ev[1] - t_ev[0], 6);
            chk("psc_period_2", t_ev[2] - t_ev[1], 6);
            chk("psc_cnt_changes", nchg, 4);
        end
        stop[0] = 1'b1;
        step();
        stop[0] = 1'b0;
        clr_it[0] = 1'b1;
        step();
        clr_it[0] = 1'b0;
        psc = '0;
        step();
        chk("psc_stop_idle", {busy[0], it[0]}, 2'b00);

        // PWM and async reset: top=9, cmp=3, psc=0
        top0 = 8'd9; cmp0 = 8'd3; dir[0] = 1'b1; periodic[0] = 1'b1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        npwm = 0;
`ifdef TIMER_BANK_PWM_EN
        if (pwm[0]) npwm++;
`endif
        for (int c = 0; c < 19; c++) begin
            step();
`ifdef TIMER_BANK_PWM_EN
            if (pwm[0]) npwm++;
`endif
        end
`ifdef TIMER_BANK_PWM_EN
        chk("pwm_high_cycles", npwm, 6);
        stop[0] = 1'b1;
        step();
        stop[0] = 1'b0;
        chk("pwm_after_stop", {pwm[0], busy[0]}, 2'b00);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        chk("pwm_restart", pwm[0], 1'b1);
`endif
        chk("pre_reset_irq", {busy[0], irq}, 2'b11);
        step();
        #2;
        rstn = 1'b0;
        #1;
        chk("async_reset", {cnt, busy, it, irq}, '0);
`ifdef TIMER_BANK_PWM_EN
        chk("async_reset_pwm", pwm, '0);
`endif
        step();
        rstn = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
